// File: rtl/io_cfg_sequencer.sv
// Config-bus write sequencer: queues {addr,data} requests in a 4-entry FIFO and plays each one
// onto the io1bit broadcast bus with data settled one cycle before and after the address window.
module io_cfg_sequencer #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter logic [31:0] IDLE_ADDR   = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        busy,
  output logic [7:0]  wr_count
);

  typedef enum logic [1:0] {StIdle, StSetup, StHold, StRecover} state_e;

  state_e      state_q, state_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  wr_count_q, wr_count_d;
  logic [31:0] cfg_addr_q, cfg_addr_d;
  logic [31:0] cfg_data_q, cfg_data_d;

  logic [63:0] fifo_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q;
  logic        push, pop;

  assign req_ready = (count_q != 3'd4);
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == StIdle) && (count_q != 3'd0);

  // Storage needs no reset: occupancy and pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {req_addr, req_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_count_d = wr_count_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          addr_d  = fifo_q[rd_ptr_q][63:32];
          data_d  = fifo_q[rd_ptr_q][31:0];
          state_d = StSetup;
        end
      end
      StSetup: begin
        hold_cnt_d = 4'(HOLD_CYCLES - 1);
        state_d    = StHold;
      end
      StHold: begin
        if (hold_cnt_q == 4'd0) state_d = StRecover;
        else                    hold_cnt_d = hold_cnt_q - 4'd1;
      end
      StRecover: begin
        wr_count_d = wr_count_q + 8'd1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Bus registers are loaded with the values belonging to the state being entered.
    cfg_addr_d = IDLE_ADDR;
    cfg_data_d = 32'h0;
    case (state_d)
      StSetup:   cfg_data_d = data_d;
      StHold: begin
        cfg_addr_d = addr_d;
        cfg_data_d = data_d;
      end
      StRecover: cfg_data_d = data_d;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      hold_cnt_q <= 4'd0;
      addr_q     <= 32'h0;
      data_q     <= 32'h0;
      wr_count_q <= 8'd0;
      cfg_addr_q <= IDLE_ADDR;
      cfg_data_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_count_q <= wr_count_d;
      cfg_addr_q <= cfg_addr_d;
      cfg_data_q <= cfg_data_d;
    end
  end

  assign config_addr = cfg_addr_q;
  assign config_data = cfg_data_q;
  assign wr_count    = wr_count_q;
  assign busy        = (state_q != StIdle) || (count_q != 3'd0);

endmodule
